// File: rtl/mips_pkg.sv
// Shared constants for the 5-stage MIPS core.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned CNT_W    = 32;

endpackage : mips_pkg

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, write-back selector and retired-instruction counter.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned REG_AW = mips_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inValid,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] Rdata,
  input  logic [DATA_W-1:0] Address,
  input  logic [REG_AW-1:0] inst,
  input  logic              Stall,
  input  logic              Flush,
  output logic              WbEn,
  output logic [REG_AW-1:0] WbReg,
  output logic [DATA_W-1:0] WbData,
  output logic              FwdValid,
  output logic [REG_AW-1:0] FwdReg,
  output logic [DATA_W-1:0] FwdData,
  output logic [CNT_W-1:0]  RetireCount
);

  logic              valid;
  logic              regwrite;
  logic              memtoreg;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] alu;
  logic [REG_AW-1:0] dst;
  logic [CNT_W-1:0]  count;

  // Slot capture with priority reset > flush > stall > capture; a slot retires when it leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      regwrite <= 1'b0;
      memtoreg <= 1'b0;
      rdata    <= '0;
      alu      <= '0;
      dst      <= '0;
      count    <= '0;
    end else if (Flush) begin
      valid    <= 1'b0;
      regwrite <= 1'b0;
      memtoreg <= 1'b0;
      rdata    <= '0;
      alu      <= '0;
      dst      <= '0;
    end else if (!Stall) begin
      valid    <= inValid;
      regwrite <= RegWrite;
      memtoreg <= MemtoReg;
      rdata    <= Rdata;
      alu      <= Address;
      dst      <= inst;
      if (valid) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Write-back select and r0-suppressed enable, driven only from stage registers.
  always_comb begin
    WbData      = memtoreg ? rdata : alu;
    WbEn        = valid && regwrite && (dst != REG_AW'(REG_ZERO));
    WbReg       = dst;
    FwdValid    = WbEn;
    FwdReg      = WbReg;
    FwdData     = WbData;
    RetireCount = count;
  end

endmodule : mem_wb_stage
